// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared fetch-stage types and helpers.
// XLEN, default reset PC, fetch_entry_t {pc, iw}, PC alignment.
package rv32i_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] iw;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(
    input logic [XLEN-1:0] a
  );
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/rv32i_fetch_unit_if.sv
// rv32i_fetch_unit_if: memory request/response and ID handshake bundle.
// master = fetch unit (mem_req/addr, id_valid/iw/pc out), slave = env.
interface rv32i_fetch_unit_if;
  import rv32i_pkg::*;

  logic            mem_req;
  logic [29:0]     mem_addr;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_iw;
  logic [XLEN-1:0] id_pc;

  modport master (
    output mem_req, mem_addr,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output id_valid, id_iw, id_pc,
    input  id_ready
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  id_valid, id_iw, id_pc,
    output id_ready
  );

endinterface

// File: rtl/rv32i_sync_fifo.sv
// rv32i_sync_fifo: synchronous FIFO, sync active-high reset, clear.
// Ports: i_push/i_pop/i_clear, i_wdata, o_rdata (head), o_count/full/empty.
module rv32i_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [CW-1:0]    r_cnt;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_rdata = r_mem[r_rp];
  assign o_count = r_cnt;
  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/rv32i_fetch_unit.sv
// rv32i_fetch_unit: RV32I fetch stage, DEPTH requests in flight, redirect.
// Ports: clk, reset, bus (master: mem req/rsp, ID handshake), redirect_*.
module rv32i_fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          DEPTH    = 4
) (
  input  logic                clk,
  input  logic                reset,
  rv32i_fetch_unit_if.master  bus,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]  r_pc;
  logic [CW-1:0] r_out;
  logic [CW-1:0] r_drop;

  logic [CW-1:0] w_ifq_cnt;
  logic [CW-1:0] w_pcq_cnt;
  logic          w_ifq_full;
  logic          w_ifq_empty;
  logic          w_pcq_full;
  logic          w_pcq_empty;
  fetch_entry_t  w_ifq_wdata;
  fetch_entry_t  w_ifq_rdata;
  logic [31:0]   w_pcq_head;
  logic [CW:0]   w_used;
  logic          w_req;
  logic          w_gnt;
  logic          w_rsp;
  logic          w_keep;
  logic          w_pop;

  // Buffered words plus in-flight requests never exceed DEPTH,
  // so a returning word always has a FIFO slot.
  assign w_used = {1'b0, w_ifq_cnt} + {1'b0, r_out};
  assign w_req  = !reset && !redirect_valid
                  && (w_used < (CW+1)'(DEPTH));
  assign w_gnt  = w_req && bus.mem_gnt;
  assign w_rsp  = bus.mem_rvalid;
  assign w_keep = w_rsp && (r_drop == '0) && !redirect_valid;
  assign w_pop  = !w_ifq_empty && bus.id_ready;

  assign w_ifq_wdata.pc = w_pcq_head;
  assign w_ifq_wdata.iw = bus.mem_rdata;

  assign bus.mem_req  = w_req;
  assign bus.mem_addr = r_pc[31:2];
  assign bus.id_valid = !w_ifq_empty;
  assign bus.id_iw    = w_ifq_empty ? '0 : w_ifq_rdata.iw;
  assign bus.id_pc    = w_ifq_empty ? '0 : w_ifq_rdata.pc;

  rv32i_sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_ifq (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_keep),
    .i_pop   (w_pop),
    .i_clear (redirect_valid),
    .i_wdata (w_ifq_wdata),
    .o_rdata (w_ifq_rdata),
    .o_count (w_ifq_cnt),
    .o_full  (w_ifq_full),
    .o_empty (w_ifq_empty)
  );

  // PCs of granted requests; dropped responses still pop their entry.
  rv32i_sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_pcq (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_gnt),
    .i_pop   (w_rsp),
    .i_clear (1'b0),
    .i_wdata (r_pc),
    .o_rdata (w_pcq_head),
    .o_count (w_pcq_cnt),
    .o_full  (w_pcq_full),
    .o_empty (w_pcq_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc   <= RESET_PC;
      r_out  <= '0;
      r_drop <= '0;
    end else begin
      r_out <= r_out + CW'(w_gnt) - CW'(w_rsp);
      if (redirect_valid) begin
        r_pc   <= align_pc(redirect_pc);
        // a response landing this cycle is already discarded
        r_drop <= r_out - CW'(w_rsp);
      end else begin
        if (w_gnt) r_pc <= r_pc + 32'd4;
        if (w_rsp && (r_drop != '0)) r_drop <= r_drop - 1'b1;
      end
    end
  end

  a_rsp_legal: assert property (@(posedge clk) disable iff (reset)
    w_rsp |-> (r_out != '0) && !w_pcq_empty);
  a_ifq_room: assert property (@(posedge clk) disable iff (reset)
    !(w_keep && w_ifq_full));
  a_pcq_room: assert property (@(posedge clk) disable iff (reset)
    !(w_gnt && w_pcq_full));
  a_pcq_sync: assert property (@(posedge clk) disable iff (reset)
    w_pcq_cnt == r_out);

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// tb_rv32i_fetch_unit: random memory/ID stimulus, scoreboard of fetch stream.
// Expected stream: consecutive PCs from last reset/redirect target.
module tb_rv32i_fetch_unit;
  import rv32i_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  always #5 clk = ~clk;

  rv32i_fetch_unit_if bus();

  rv32i_fetch_unit #(
    .RESET_PC (RST_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int gcnt = 0;
  int hs_cnt = 0;
  int gnt_pct = 100;
  int rdy_pct = 100;
  int lat_lo = 1;
  int lat_hi = 1;
  logic prev_rst = 1'b0;

  typedef struct {
    logic [29:0] a;
    int          due;
  } pend_t;
  pend_t pend[$];

  logic [31:0] exp_q[$];
  logic [31:0] exp_next;

  function automatic logic [31:0] mem_word(input logic [29:0] wa);
    return ({2'b00, wa} * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic void refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back(exp_next);
      exp_next = exp_next + 32'd4;
    end
  endfunction

  function automatic void restart(input logic [31:0] t);
    exp_q.delete();
    exp_next = t;
    refill();
  endfunction

  // memory model: in-order responses, per-request latency
  always @(negedge clk) begin
    if (reset) begin
      pend.delete();
    end else begin
      if (bus.mem_rvalid && pend.size() > 0) void'(pend.pop_front());
      if (bus.mem_req && bus.mem_gnt) begin
        pend.push_back('{a: bus.mem_addr,
          due: cyc + int'($urandom_range(lat_hi, lat_lo))});
        gcnt++;
      end
    end
    cyc++;
  end

  // input driver
  always @(posedge clk) begin
    #2;
    bus.mem_gnt  = (int'($urandom_range(99, 0)) < gnt_pct);
    bus.id_ready = (int'($urandom_range(99, 0)) < rdy_pct);
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = mem_word(pend[0].a);
    end else begin
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = $urandom;
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (prev_rst) begin
      chk("rst_id_valid", bus.id_valid, 0);
      chk("rst_id_iw", bus.id_iw, 0);
      chk("rst_id_pc", bus.id_pc, 0);
      chk("rst_mem_addr", bus.mem_addr, RST_PC[31:2]);
      chk("rst_mem_req", bus.mem_req, !reset && !redirect_valid);
    end
    if (reset) begin
      chk("req_in_reset", bus.mem_req, 0);
      restart(RST_PC);
    end else begin
      if (redirect_valid) chk("req_in_redirect", bus.mem_req, 0);
      if (bus.id_valid) begin
        chk("id_pc", bus.id_pc, exp_q[0]);
        chk("id_iw", bus.id_iw, mem_word(exp_q[0][31:2]));
        if (bus.id_ready) begin
          void'(exp_q.pop_front());
          hs_cnt++;
          refill();
        end
      end
      if (redirect_valid) restart(redirect_pc & 32'hFFFF_FFFC);
    end
    prev_rst = reset;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    tick();
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic wait_pc(input string nm, input logic [31:0] pc,
                         input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      look();
      if (bus.id_valid && bus.id_pc == pc) seen = 1'b1;
    end
    chk(nm, seen, 1);
  endtask

  initial begin
    int h0;
    int g0;
    logic [29:0] a0;

    // fill timing and throughput, 1-cycle memory
    do_reset(2);
    h0 = 0;
    for (int k = 0; k < 12; k++) begin
      look();
      if (k == 0) begin
        chk("first_req", bus.mem_req, 1);
        chk("first_addr", bus.mem_addr, RST_PC[31:2]);
        chk("valid_c0", bus.id_valid, 0);
      end
      if (k == 1) begin
        chk("valid_c1", bus.id_valid, 0);
        h0 = hs_cnt;
      end
      if (k == 2) begin
        chk("valid_c2", bus.id_valid, 1);
        chk("pc_c2", bus.id_pc, RST_PC);
      end
    end
    chk("throughput", hs_cnt - h0, 10);

    // backpressure fills DEPTH entries
    rdy_pct = 0;
    do_reset(2);
    g0 = gcnt;
    repeat (10) look();
    chk("stall_grants", gcnt - g0, DEPTH);
    chk("stall_req_low", bus.mem_req, 0);
    tick();
    rdy_pct = 100;
    h0 = hs_cnt;
    repeat (12) look();
    chk("resume_hs", (hs_cnt - h0) >= 8, 1);

    // redirect with 3 in flight, 3-cycle memory
    lat_lo = 3;
    lat_hi = 3;
    do_reset(2);
    repeat (3) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    look();
    chk("redir_req_r", bus.mem_req, 0);
    tick();
    redirect_valid = 1'b0;
    look();
    chk("redir_valid_r1", bus.id_valid, 0);
    chk("redir_req_r1", bus.mem_req, 1);
    chk("redir_addr_r1", bus.mem_addr, 30'h40);
    wait_pc("redir_target", 32'h0000_0100, 12);

    // redirect coincident with response and pop
    lat_lo = 1;
    lat_hi = 1;
    do_reset(2);
    repeat (6) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0203;
    h0 = hs_cnt;
    look();
    chk("coinc_valid", bus.id_valid, 1);
    chk("coinc_pop", hs_cnt - h0, 1);
    tick();
    redirect_valid = 1'b0;
    look();
    chk("coinc_valid_r1", bus.id_valid, 0);
    wait_pc("coinc_target", 32'h0000_0200, 10);

    // grant withheld five cycles
    tick();
    gnt_pct = 0;
    a0 = '0;
    for (int k = 0; k < 5; k++) begin
      look();
      if (k == 0) a0 = bus.mem_addr;
      chk("hold_req", bus.mem_req, 1);
      chk("hold_addr", bus.mem_addr, a0);
    end
    tick();
    gnt_pct = 100;
    look();
    chk("resume_addr", bus.mem_addr, a0);
    repeat (6) tick();

    // PC wrap
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    wait_pc("wrap_zero", 32'h0000_0000, 12);

    // reset mid-stream beats a coincident redirect
    lat_lo = 3;
    lat_hi = 3;
    repeat (5) tick();
    reset = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0500;
    tick();
    reset = 1'b0;
    redirect_valid = 1'b0;
    look();
    chk("mid_rst_valid", bus.id_valid, 0);
    chk("mid_rst_addr", bus.mem_addr, RST_PC[31:2]);
    wait_pc("mid_rst_restart", RST_PC, 12);

    // random soak
    gnt_pct = 70;
    rdy_pct = 60;
    lat_lo = 1;
    lat_hi = 4;
    h0 = hs_cnt;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (int'($urandom_range(99, 0)) < 3) begin
        redirect_valid = 1'b1;
        redirect_pc = $urandom;
      end else begin
        redirect_valid = 1'b0;
      end
    end
    tick();
    redirect_valid = 1'b0;
    repeat (20) tick();
    chk("random_progress", (hs_cnt - h0) > 200, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
